dtc_sync_mc: RTL
================

Name: dtc_sync_mc

Overview:
Synchronous multi-channel digital-to-time converter (DTC) for the time-domain MAC datapath. It is the clocked, parametrised successor to the binary-weighted delay-chain DTCs.
- Accepts one code per channel via valid/ready handshake.
- Runs one conversion frame on a shared prescaled timebase.
- Each channel output is either a delayed rising edge (edge mode) or a pulse whose width is proportional to its code (width mode).
- Feeds the time-domain accumulator; `done` marks frame end.

Parameters:
WIDTH, 8, code width per channel; frame spans 2^WIDTH ticks
CHANNELS, 4, number of independent DTC channels
UNIT_CYC, 1, clock cycles per LSB tick (>=1); replaces DEL_UNIT

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  code vector and mode valid
in_ready  output  1  high only in IDLE
code  input  CHANNELS*WIDTH  channel i code = code[i*WIDTH +: WIDTH], unsigned
mode  input  1  0 = edge mode, 1 = width mode; latched with codes
abort  input  1  terminates running frame
out  output  CHANNELS  time-encoded channel outputs, registered
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at normal frame end

Behaviour:
- Reset: sampled on a clk edge with rst=1. Next cycle: state=IDLE; out=0; done=0; busy=0; in_ready=1; prescaler, tick counter and code/mode registers all 0. Reset mid-frame aborts immediately; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on in_valid & in_ready at cycle t. code and mode are latched; RUN begins at cycle t+1. in_valid without in_ready is ignored; no queuing.
- RUN indexing: k = cycles since RUN entry, k=0 at t+1. tick = floor(k/UNIT_CYC), from a prescaler (0..UNIT_CYC-1) and a WIDTH-bit tick counter.
- RUN length: exactly 2^WIDTH*UNIT_CYC cycles (k = 0 .. 2^WIDTH*UNIT_CYC-1). The tick counter must not wrap back to 0 inside the frame; final tick value is 2^WIDTH-1.
- Edge mode, in cycle k: out[i] = (tick >= code[i]).
  - code 0 -> high from k=0.
  - code 2^WIDTH-1 -> high for the last UNIT_CYC cycles only.
- Width mode, in cycle k: out[i] = (tick < code[i]).
  - code 0 -> never high.
  - Max code -> high for all but the last UNIT_CYC cycles.
- Outputs are registered so the equations above hold in the cycle with index k, not one cycle later.
- RUN -> DONE: after the last RUN cycle. In DONE: done=1 for exactly one cycle; out=0.
- DONE -> IDLE: unconditional; in_ready returns high the following cycle. Minimum handshake-to-handshake spacing is 2^WIDTH*UNIT_CYC + 2 cycles.
- abort:
  - Sampled in RUN: next cycle state=IDLE, out=0, no done.
  - In IDLE or DONE: ignored.
  - abort together with the last RUN cycle: abort wins, no done.
- rst has priority over abort, and abort over normal sequencing.
- Codes and mode are stable for the whole frame; input changes during RUN have no effect.

Optional Feature:
DTC_OFFSET_EN
- Defined:
  - Adds port `offset`, input, WIDTH bits, unsigned, latched at handshake together with code.
  - Effective code per channel = min(code[i] + offset, 2^WIDTH-1), computed at WIDTH+1 bits and saturated before latching. Models a common-mode delay offset.
- Undefined: no offset port; effective code = code[i].

Test Plan:
- Setup for all cases unless noted: WIDTH=4, CHANNELS=2, UNIT_CYC=2, so RUN = 32 cycles.
- Edge mode, code ch0=3, ch1=0, handshake at t -> out[0] rises at t+7 (k=6); out[1] high from t+1; done high only at t+33; in_ready high at t+34.
- Width mode, ch0=15, ch1=0 -> out[0] high for k=0..29 (30 cycles); out[1] never high; done at t+33.
- abort asserted at k=10 of an edge-mode frame, codes 5/5 -> out=0 and state IDLE at k=11; no done pulse; new handshake is accepted on the next cycle.
- rst asserted mid-RUN at k=4 -> next cycle out=0, busy=0, in_ready=1; subsequent frame with code 1 -> out[0] rises at k=2.
- in_valid held high continuously, codes 2/2 -> exactly one frame per 34 cycles; in_valid is never accepted while busy=1.
- DTC_OFFSET_EN defined, offset=14, code ch0=3, ch1=1, edge mode -> effective codes 15 (saturated) and 15; both outputs rise at k=30.

Source files
------------

// File: rtl/dtc_sync_mc.sv
// -----------------------------------------------------------------------------
// dtc_sync_mc
// Synchronous multi-channel digital-to-time converter. One code vector is
// accepted per frame through a valid/ready handshake. The frame runs for
// 2^WIDTH ticks of UNIT_CYC clock cycles each. Each channel output is a delayed
// rising edge (edge mode) or a pulse whose width is proportional to its code
// (width mode). `done` pulses for one cycle at the end of a normal frame.
//
// Optional feature (compile-time macro DTC_OFFSET_EN):
//   Adds the `offset` input. It is added to every channel code at handshake and
//   saturated at 2^WIDTH-1 before latching.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   code vector and mode valid
//   in_ready  out  high only while idle
//   code      in   CHANNELS*WIDTH; channel i = code[i*WIDTH +: WIDTH]
//   mode      in   0 = edge mode, 1 = width mode
//   offset    in   WIDTH; common code offset (DTC_OFFSET_EN only)
//   abort     in   terminates a running frame, no done pulse
//   out       out  CHANNELS time-encoded outputs, registered
//   busy      out  state != IDLE
//   done      out  one-cycle pulse at normal frame end
// -----------------------------------------------------------------------------
module dtc_sync_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int UNIT_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] code,
  input  logic                      mode,
`ifdef DTC_OFFSET_EN
  input  logic [WIDTH-1:0]          offset,
`endif
  input  logic                      abort,
  output logic [CHANNELS-1:0]       out,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Prescaler needs at least one bit even when UNIT_CYC == 1.
  localparam int               PW        = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(UNIT_CYC - 1);
  localparam logic [WIDTH-1:0] TICK_LAST = {WIDTH{1'b1}};

  state_t                    state_reg, state_next;
  logic [PW-1:0]             pre_reg, pre_next;
  logic [WIDTH-1:0]          tick_reg, tick_next;
  logic [CHANNELS*WIDTH-1:0] code_reg, code_next;
  logic                      mode_reg, mode_next;
  logic [CHANNELS-1:0]       out_reg, out_next;

  logic [CHANNELS*WIDTH-1:0] eff_code;
  logic                      hs;
  logic                      last_cycle;

  assign hs         = in_valid && (state_reg == IDLE);
  assign last_cycle = (pre_reg == PRE_LAST) && (tick_reg == TICK_LAST);

  // Effective code per channel, formed before latching.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_eff
`ifdef DTC_OFFSET_EN
      logic [WIDTH:0] sum;
      assign sum = {1'b0, code[gi*WIDTH +: WIDTH]} + {1'b0, offset};
      assign eff_code[gi*WIDTH +: WIDTH] = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
      assign eff_code[gi*WIDTH +: WIDTH] = code[gi*WIDTH +: WIDTH];
`endif
    end
  endgenerate

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pre_reg   <= '0;
      tick_reg  <= '0;
      code_reg  <= '0;
      mode_reg  <= 1'b0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pre_reg   <= pre_next;
      tick_reg  <= tick_next;
      code_reg  <= code_next;
      mode_reg  <= mode_next;
      out_reg   <= out_next;
    end
  end

  // Next-state and next-datapath logic. abort outranks the normal end of frame.
  always_comb begin
    state_next = state_reg;
    pre_next   = pre_reg;
    tick_next  = tick_reg;
    code_next  = code_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (hs) begin
          state_next = RUN;
          code_next  = eff_code;
          mode_next  = mode;
          pre_next   = '0;
          tick_next  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (last_cycle) begin
          state_next = DONE;
        end
        if (state_next != RUN) begin
          // Leaving the frame: clear counters, never wrap inside the frame.
          pre_next  = '0;
          tick_next = '0;
        end else if (pre_reg == PRE_LAST) begin
          pre_next  = '0;
          tick_next = tick_reg + 1'b1;
        end else begin
          pre_next  = pre_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The output register is loaded from the *next* tick so that out already
  // reflects tick k during RUN cycle k (including k = 0 right after handshake).
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_out
      logic edge_hit;
      assign edge_hit     = (tick_next >= code_next[gi*WIDTH +: WIDTH]);
      assign out_next[gi] = (state_next == RUN) && (mode_next ? !edge_hit : edge_hit);
    end
  endgenerate

  // Output logic
  always_comb begin
    in_ready = (state_reg == IDLE);
    busy     = (state_reg != IDLE);
    done     = (state_reg == DONE);
    out      = out_reg;
  end

endmodule
